cv32e40p_clock_gate_ctrl: RTL and testbench

Parametrised multi-domain clock-gating controller for the CV32E40P top level. It replaces the fixed, directly-driven gate cells with `NUM_CH` independent channels. Each channel runs an idle-hysteresis/wake-latency state machine, an acknowledge handshake and a saturating gated-cycle counter. It sits beside `cv32e40p_core` and drives the gated clocks of the core-adjacent domains (APU/FPU, power-gated clock, auxiliary logic).

---
 rtl/cv32e40p_cg_pkg.sv | 23 ++
 rtl/cv32e40p_cg_channel.sv | 127 ++++++++++++
 rtl/cv32e40p_clock_gate.sv | 19 +
 rtl/cv32e40p_clock_gate_ctrl.sv | 47 ++++
 tb/tb_cv32e40p_clock_gate_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cv32e40p_cg_pkg.sv
// Shared types and encodings for the multi-channel clock-gating controller.
package cv32e40p_cg_pkg;

  localparam logic [1:0] CgOffEnc   = 2'd0;
  localparam logic [1:0] CgWakeEnc  = 2'd1;
  localparam logic [1:0] CgOnEnc    = 2'd2;
  localparam logic [1:0] CgDrainEnc = 2'd3;

  typedef enum logic [1:0] {
    CgOff   = CgOffEnc,
    CgWake  = CgWakeEnc,
    CgOn    = CgOnEnc,
    CgDrain = CgDrainEnc
  } cg_state_e;

  // Width of a counter holding 0..n, never narrower than one bit.
  function automatic int cg_cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cv32e40p_cg_channel.sv
// One gated-clock channel: idle-hysteresis / wake-latency FSM, saturating OFF counter
// and the gate cell it drives.
module cv32e40p_cg_channel
  import cv32e40p_cg_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int RST_ON      = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             scan_cg_en_i,
  input  logic             wake_req_i,
  input  logic             idle_i,
  input  logic             force_on_i,
  input  logic             cnt_clr_i,
  output logic             clk_o,
  output logic             en_o,
  output logic             ack_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] gated_cnt_o
);

  localparam int IdleW = cg_cnt_w(IDLE_CYCLES);
  localparam int WakeW = cg_cnt_w(WAKE_CYCLES);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_CYCLES - 1);
  localparam logic [WakeW-1:0] WakeLast = WakeW'(WAKE_CYCLES - 1);
  localparam cg_state_e RstState = (RST_ON != 0) ? CgOn : CgOff;

  cg_state_e        state_q, state_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] gated_cnt_q, gated_cnt_d;
  logic             en_q, en_d;
  logic             ack_q, ack_d;

  logic wake_hit;
  logic idle_qual;

  assign wake_hit  = wake_req_i | force_on_i;
  assign idle_qual = idle_i & ~wake_hit;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      CgOn: begin
        if (idle_qual) begin
          idle_cnt_d = IdleW'(1);
          state_d    = (IDLE_CYCLES == 1) ? CgOff : CgDrain;
        end
      end
      CgDrain: begin
        if (!idle_qual) begin
          state_d    = CgOn;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IdleLast) begin
          state_d    = CgOff;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IdleW'(1);
        end
      end
      CgOff: begin
        // idle_i is deliberately ignored here; only a wake source leaves OFF.
        if (wake_hit) begin
          wake_cnt_d = '0;
          state_d    = (WAKE_CYCLES == 0) ? CgOn : CgWake;
        end
      end
      CgWake: begin
        if (wake_cnt_q == WakeLast) begin
          state_d    = CgOn;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WakeW'(1);
        end
      end
    endcase
  end

  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if (cnt_clr_i) begin
      gated_cnt_d = '0;
    end else if (state_q == CgOff && !(&gated_cnt_q)) begin
      gated_cnt_d = gated_cnt_q + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they always match state_q.
  assign en_d  = (state_d != CgOff);
  assign ack_d = (state_d == CgOn) || (state_d == CgDrain);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RstState;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      gated_cnt_q <= '0;
      en_q        <= (RST_ON != 0);
      ack_q       <= (RST_ON != 0);
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      gated_cnt_q <= gated_cnt_d;
      en_q        <= en_d;
      ack_q       <= ack_d;
    end
  end

  cv32e40p_clock_gate u_clock_gate (
    .clk_i        (clk_i),
    .en_i         (en_q),
    .scan_cg_en_i (scan_cg_en_i),
    .clk_o        (clk_o)
  );

  assign en_o        = en_q;
  assign ack_o       = ack_q;
  assign state_o     = state_q;
  assign gated_cnt_o = gated_cnt_q;

endmodule

// File: rtl/cv32e40p_clock_gate.sv
// Latch-based clock gate: enable is captured while clk_i is low, so clk_o never glitches.
module cv32e40p_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_latch;

  always_latch begin
    if (!clk_i) begin
      en_latch = en_i | scan_cg_en_i;
    end
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cv32e40p_clock_gate_ctrl.sv
// Multi-domain clock-gating controller: NUM_CH independent gated-clock channels.
module cv32e40p_clock_gate_ctrl
  import cv32e40p_cg_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16,
  parameter int RST_ON      = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    scan_cg_en_i,
  input  logic [NUM_CH-1:0]       wake_req_i,
  input  logic [NUM_CH-1:0]       idle_i,
  input  logic [NUM_CH-1:0]       force_on_i,
  input  logic                    cnt_clr_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       en_o,
  output logic [NUM_CH-1:0]       ack_o,
  output logic [2*NUM_CH-1:0]     state_o,
  output logic [NUM_CH*CNT_W-1:0] gated_cnt_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    cv32e40p_cg_channel #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES),
      .CNT_W       (CNT_W),
      .RST_ON      (RST_ON)
    ) u_channel (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .scan_cg_en_i (scan_cg_en_i),
      .wake_req_i   (wake_req_i[i]),
      .idle_i       (idle_i[i]),
      .force_on_i   (force_on_i[i]),
      .cnt_clr_i    (cnt_clr_i),
      .clk_o        (clk_o[i]),
      .en_o         (en_o[i]),
      .ack_o        (ack_o[i]),
      .state_o      (state_o[2*i +: 2]),
      .gated_cnt_o  (gated_cnt_o[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// Directed bench with a scoreboard queue drained by a negedge monitor.
module tb_cv32e40p_clock_gate_ctrl;

  localparam int NumCh = 2;
  localparam int CntW  = 4;

  localparam int KEn    = 0;
  localparam int KAck   = 1;
  localparam int KState = 2;
  localparam int KCnt0  = 3;
  localparam int KCnt1  = 4;
  localparam int KClk0  = 5;
  localparam int KClk1  = 6;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic                  scan;
  logic [NumCh-1:0]      wake_req;
  logic [NumCh-1:0]      idle;
  logic [NumCh-1:0]      force_on;
  logic                  cnt_clr;
  logic [NumCh-1:0]      gclk;
  logic [NumCh-1:0]      en;
  logic [NumCh-1:0]      ack;
  logic [2*NumCh-1:0]    state;
  logic [NumCh*CntW-1:0] gcnt;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   clk0_pulses = 0;
  int   clk1_pulses = 0;

  cv32e40p_clock_gate_ctrl #(
    .NUM_CH      (NumCh),
    .IDLE_CYCLES (4),
    .WAKE_CYCLES (2),
    .CNT_W       (CntW),
    .RST_ON      (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .scan_cg_en_i (scan),
    .wake_req_i   (wake_req),
    .idle_i       (idle),
    .force_on_i   (force_on),
    .cnt_clr_i    (cnt_clr),
    .clk_o        (gclk),
    .en_o         (en),
    .ack_o        (ack),
    .state_o      (state),
    .gated_cnt_o  (gcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge gclk[0]) clk0_pulses++;
  always @(posedge gclk[1]) clk1_pulses++;

  // Monitor: compares every pending expectation against the DUT away from the active edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        KEn:     act = 32'(en);
        KAck:    act = 32'(ack);
        KState:  act = 32'(state);
        KCnt0:   act = 32'(gcnt[CntW-1:0]);
        KCnt1:   act = 32'(gcnt[2*CntW-1:CntW]);
        KClk0:   act = 32'(clk0_pulses);
        KClk1:   act = 32'(clk1_pulses);
        default: act = 32'hdead_beef;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = val;
    sb.push_back(e);
  endtask

  task automatic clr_pulses();
    clk0_pulses = 0;
    clk1_pulses = 0;
  endtask

  // state_o = {ch1, ch0}; ON=2, DRAIN=3, OFF=0, WAKE=1
  initial begin
    rst = 1'b1; scan = 1'b0; wake_req = '0; idle = '0; force_on = '0; cnt_clr = 1'b0;

    step(2);
    expect_v(KState, 4'b1010, "reset_state");
    expect_v(KEn,    2'b11,   "reset_en");
    expect_v(KAck,   2'b11,   "reset_ack");
    expect_v(KCnt0,  0,       "reset_cnt0");
    expect_v(KCnt1,  0,       "reset_cnt1");
    rst = 1'b0;

    // Idle gating: OFF after exactly four idle-qualified edges
    idle[0] = 1'b1;
    step(3);
    expect_v(KState, 4'b1011, "drain_after_3");
    expect_v(KEn,    2'b11,   "en_after_3");
    step(1);
    expect_v(KState, 4'b1000, "off_after_4");
    expect_v(KEn,    2'b10,   "en_after_4");
    expect_v(KAck,   2'b10,   "ack_after_4");
    clr_pulses();
    step(10);
    expect_v(KCnt0, 10, "gated_cnt_10");
    expect_v(KClk0, 0,  "clk0_stopped");
    expect_v(KClk1, 10, "clk1_running");

    step(10);
    expect_v(KCnt0, 15, "gated_cnt_sat");

    // Scan forces the gate open without disturbing state
    scan = 1'b1;
    clr_pulses();
    step(4);
    expect_v(KClk0,  4,       "scan_clk0");
    expect_v(KState, 4'b1000, "scan_state");
    expect_v(KEn,    2'b10,   "scan_en");
    scan = 1'b0;

    cnt_clr = 1'b1;
    step(1);
    expect_v(KCnt0, 0, "cnt_clr");
    cnt_clr = 1'b0;
    step(1);
    expect_v(KCnt0, 1, "cnt_after_clr");

    // Single-cycle wake pulse: en now, ack two edges later, no abort
    wake_req[0] = 1'b1; idle[0] = 1'b0;
    step(1);
    expect_v(KState, 4'b1001, "wake_state");
    expect_v(KEn,    2'b11,   "wake_en");
    expect_v(KAck,   2'b10,   "wake_ack0");
    wake_req[0] = 1'b0;
    step(1);
    expect_v(KState, 4'b1001, "wake_no_abort");
    expect_v(KAck,   2'b10,   "wake_ack1");
    step(1);
    expect_v(KState, 4'b1010, "wake_on");
    expect_v(KAck,   2'b11,   "wake_ack2");

    // Hysteresis break
    idle[0] = 1'b1;
    step(3);
    idle[0] = 1'b0;
    step(1);
    expect_v(KState, 4'b1010, "hyst_back_on");
    idle[0] = 1'b1;
    step(3);
    expect_v(KState, 4'b1011, "hyst_drain");
    expect_v(KEn,    2'b11,   "hyst_en");
    idle[0] = 1'b0;
    step(1);

    force_on[0] = 1'b1; idle[0] = 1'b1;
    step(100);
    expect_v(KState, 4'b1010, "force_state");
    expect_v(KEn,    2'b11,   "force_en");
    force_on[0] = 1'b0;
    step(2);
    wake_req[0] = 1'b1;
    step(1);
    expect_v(KState, 4'b1010, "wake_beats_idle");
    wake_req[0] = 1'b0;
    step(4);
    expect_v(KState, 4'b1000, "off_again");
    idle[0] = 1'b0;

    // Reset in the middle of WAKE
    wake_req[0] = 1'b1;
    step(1);
    expect_v(KState, 4'b1001, "pre_rst_wake");
    wake_req[0] = 1'b0;
    rst = 1'b1;
    step(1);
    expect_v(KState, 4'b1010, "rst_mid_wake_state");
    expect_v(KEn,    2'b11,   "rst_mid_wake_en");
    expect_v(KAck,   2'b11,   "rst_mid_wake_ack");
    expect_v(KCnt0,  0,       "rst_mid_wake_cnt");
    rst = 1'b0;

    step(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
